mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- E-stage multi-cycle multiply/divide unit for the P6 pipeline. Owns the HI/LO registers.
- It is the producing end of the MDU stall handshake: it drives `busy`, and the stall unit combines `busy | start` to freeze D-stage MDU instructions.
- It executes mult/multu/div/divu, mthi/mtlo writes and mfhi/mflo reads.

Parameters:
MULT_CYCLES, 5, cycles `busy` stays high for mult/multu (must be >=1)
DIV_CYCLES, 10, cycles `busy` stays high for div/divu (must be >=1)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high; clears all state
start  input  1  one-cycle pulse while a mult/multu/div/divu instruction is in E
mdu_op  input  4  E-stage op: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO; others treated as NONE
rs_data  input  32  forwarded rs operand (dividend / multiplicand / mthi-mtlo source)
rt_data  input  32  forwarded rt operand (divisor / multiplier)
busy  output  1  operation in progress; registered
hi  output  32  architectural HI register
lo  output  32  architectural LO register
mdu_out  output  32  combinational read port: HI if MFHI, LO if MFLO, else 0

Behaviour:
- Reset: `busy`=0, `hi`=0, `lo`=0, counter=0, state=IDLE. Reset overrides every other input on the same edge and aborts any in-flight operation; HI/LO do not receive its result.
- States:
  - IDLE: counter=0.
  - BUSY: counter>0.
- IDLE -> BUSY: on an edge with `start`=1 and mdu_op in {MULT, MULTU, DIV, DIVU}.
  - Operands are latched and the result is computed into internal hi_next/lo_next.
  - Counter is loaded with MULT_CYCLES or DIV_CYCLES.
- `start` with any other mdu_op: ignored.
- Timing: `start` sampled at edge E0 -> `busy`=1 for exactly N cycles (N = MULT_CYCLES or DIV_CYCLES) following E0.
- BUSY: counter decrements each edge. On the edge where counter goes 1->0:
  - `hi`/`lo` are loaded from hi_next/lo_next.
  - `busy` falls.
  - State returns to IDLE.
- `start` while `busy`=1 violates the handshake contract; it is ignored and the current operation completes unaffected.
- mthi/mtlo: when `busy`=0 and mdu_op=MTHI (MTLO), `hi` (`lo`) is loaded with `rs_data` on the edge. They are ignored while `busy`=1; the stall unit prevents that case.
- Arithmetic:
  - MULT: signed 32x32 -> 64; hi = product[63:32], lo = product[31:0].
  - MULTU: same, unsigned.
  - DIV: signed; quotient truncates toward zero; remainder takes the sign of the dividend; lo = quotient, hi = remainder.
  - DIV overflow case 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
  - DIVU: unsigned; lo = quotient, hi = remainder.
  - Divisor 0 (DIV or DIVU): the op still runs the full DIV_CYCLES with `busy` high; hi/lo are unchanged at completion.
- mdu_out:
  - Purely combinational from mdu_op and the current hi/lo.
  - It does not bypass a completing operation: a read in the same cycle as the final busy cycle returns the old value. This cannot occur, because the stall unit holds mfhi/mflo in D.
- `hi`/`lo` are stable throughout BUSY and change only at completion, on mthi/mtlo, or on reset.

Test Plan:
- Reset, then `start`+MULT with rs=0xFFFFFFFE (-2), rt=3 -> `busy` high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA; MFLO gives mdu_out=0xFFFFFFFA.
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> after 5 busy cycles hi=0xFFFFFFFE, lo=0x00000001.
- DIV rs=-7 (0xFFFFFFF9), rt=2 -> `busy` high 10 cycles; lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Repeat as DIVU 100/7 -> lo=14, hi=2.
- Preload hi=0x1234 and lo=0x5678 via MTHI/MTLO, then DIV by 0 -> `busy` high 10 cycles; hi=0x1234, lo=0x5678 unchanged.
- Start MULT 5x5, assert `reset` on the 3rd busy cycle -> next cycle `busy`=0, hi=lo=0; no later update occurs.
- During BUSY, apply `start`+DIV and MTHI rs=0xAAAA -> both ignored; `busy` falls at the original cycle; hi/lo equal the original MULT result.

Source files
------------

// File: rtl/mult_div_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : mult_div_unit_if
//  Description : Bundle of the E-stage MDU request/response signals.
//                master : pipeline side (drives op + operands, reads status)
//                slave  : mult_div_unit side
//  Signals     : start    - one-cycle pulse for mult/multu/div/divu
//                mdu_op   - E-stage op code (4 bits)
//                rs_data  - forwarded rs operand
//                rt_data  - forwarded rt operand
//                busy     - operation in progress (registered)
//                hi, lo   - architectural HI/LO registers
//                mdu_out  - combinational mfhi/mflo read port
//  Revision    : 1.0 - initial release
// ============================================================================
interface mult_div_unit_if;
    logic        start;
    logic [3:0]  mdu_op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] mdu_out;

    modport master (
        output start, mdu_op, rs_data, rt_data,
        input  busy, hi, lo, mdu_out
    );

    modport slave (
        input  start, mdu_op, rs_data, rt_data,
        output busy, hi, lo, mdu_out
    );
endinterface
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mult_div_unit
//  Description : Multi-cycle multiply/divide unit for the E stage. Owns the
//                HI/LO registers and drives the busy half of the MDU stall
//                handshake. The arithmetic result is computed when the op is
//                accepted and held in hi_next/lo_next; it is committed to
//                HI/LO only when the cycle counter expires.
//  Ports       : clk   - system clock, rising edge
//                reset - synchronous active-high reset, clears all state
//                mdu   - mult_div_unit_if.slave (start, mdu_op, rs_data,
//                        rt_data in; busy, hi, lo, mdu_out out)
//  Parameters  : MULT_CYCLES - busy cycles for mult/multu (>=1)
//                DIV_CYCLES  - busy cycles for div/divu   (>=1)
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  wire logic     clk,
    input  wire logic     reset,
    mult_div_unit_if.slave mdu
);

    // ------------------------------------------------------------------
    // Op codes
    // ------------------------------------------------------------------
    localparam logic [3:0] c_OP_MULT  = 4'd1;
    localparam logic [3:0] c_OP_MULTU = 4'd2;
    localparam logic [3:0] c_OP_DIV   = 4'd3;
    localparam logic [3:0] c_OP_DIVU  = 4'd4;
    localparam logic [3:0] c_OP_MTHI  = 4'd5;
    localparam logic [3:0] c_OP_MTLO  = 4'd6;
    localparam logic [3:0] c_OP_MFHI  = 4'd7;
    localparam logic [3:0] c_OP_MFLO  = 4'd8;

    // ------------------------------------------------------------------
    // FSM encoding and counter sizing
    // ------------------------------------------------------------------
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    localparam int c_MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int c_CNT_W      = $clog2(c_MAX_CYCLES + 1);

    localparam logic [c_CNT_W-1:0] c_CNT_MULT = c_CNT_W'(MULT_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_DIV  = c_CNT_W'(DIV_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [0:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_busy;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;
    logic [31:0]        r_hi_next;
    logic [31:0]        r_lo_next;
    logic               r_commit;    // cleared for divide-by-zero: HI/LO untouched

    // ------------------------------------------------------------------
    // Op decode
    // ------------------------------------------------------------------
    logic w_is_mul;
    logic w_is_div;
    logic w_is_signed;

    assign w_is_mul    = (mdu.mdu_op == c_OP_MULT) || (mdu.mdu_op == c_OP_MULTU);
    assign w_is_div    = (mdu.mdu_op == c_OP_DIV)  || (mdu.mdu_op == c_OP_DIVU);
    assign w_is_signed = (mdu.mdu_op == c_OP_MULT) || (mdu.mdu_op == c_OP_DIV);

    // ------------------------------------------------------------------
    // Multiply: sign/zero extend to 64 bits; the low 64 bits of the
    // product are then correct for both signed and unsigned forms.
    // ------------------------------------------------------------------
    logic [63:0] w_mul_a;
    logic [63:0] w_mul_b;
    logic [63:0] w_product;

    assign w_mul_a   = w_is_signed ? {{32{mdu.rs_data[31]}}, mdu.rs_data} : {32'd0, mdu.rs_data};
    assign w_mul_b   = w_is_signed ? {{32{mdu.rt_data[31]}}, mdu.rt_data} : {32'd0, mdu.rt_data};
    assign w_product = w_mul_a * w_mul_b;

    // ------------------------------------------------------------------
    // Divide on magnitudes, then restore signs. Quotient is negative when
    // operand signs differ (truncation toward zero); remainder follows the
    // dividend. 0x80000000 / -1 falls out naturally: magnitude quotient
    // 0x80000000, signs equal, so LO = 0x80000000 and HI = 0.
    // A zero divisor is replaced by 1 so the divider never sees 0; the
    // result is discarded via r_commit anyway.
    // ------------------------------------------------------------------
    logic        w_a_neg;
    logic        w_b_neg;
    logic        w_div_zero;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_quot;
    logic [31:0] w_rem;

    assign w_div_zero = (mdu.rt_data == 32'd0);
    assign w_a_neg    = w_is_signed && mdu.rs_data[31];
    assign w_b_neg    = w_is_signed && mdu.rt_data[31];
    assign w_a_mag    = w_a_neg ? (32'd0 - mdu.rs_data) : mdu.rs_data;
    assign w_b_mag    = w_div_zero ? 32'd1 :
                        (w_b_neg ? (32'd0 - mdu.rt_data) : mdu.rt_data);
    assign w_q_mag    = w_a_mag / w_b_mag;
    assign w_r_mag    = w_a_mag % w_b_mag;
    assign w_quot     = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
    assign w_rem      = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;

    // ------------------------------------------------------------------
    // Result selection
    // ------------------------------------------------------------------
    logic [31:0]        w_hi_next;
    logic [31:0]        w_lo_next;
    logic               w_commit;
    logic [c_CNT_W-1:0] w_cnt_load;

    always_comb begin
        w_hi_next  = w_product[63:32];
        w_lo_next  = w_product[31:0];
        w_commit   = 1'b1;
        w_cnt_load = c_CNT_MULT;
        if (w_is_div) begin
            w_hi_next  = w_rem;
            w_lo_next  = w_quot;
            w_commit   = !w_div_zero;
            w_cnt_load = c_CNT_DIV;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer and HI/LO
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_hi_next <= 32'd0;
            r_lo_next <= 32'd0;
            r_commit  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (mdu.start && (w_is_mul || w_is_div)) begin
                        r_state   <= S_BUSY;
                        r_cnt     <= w_cnt_load;
                        r_busy    <= 1'b1;
                        r_hi_next <= w_hi_next;
                        r_lo_next <= w_lo_next;
                        r_commit  <= w_commit;
                    end else if (mdu.mdu_op == c_OP_MTHI) begin
                        r_hi <= mdu.rs_data;
                    end else if (mdu.mdu_op == c_OP_MTLO) begin
                        r_lo <= mdu.rs_data;
                    end
                end
                S_BUSY: begin
                    // start/mthi/mtlo are deliberately ignored here.
                    r_cnt <= r_cnt - c_CNT_ONE;
                    if (r_cnt == c_CNT_ONE) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        if (r_commit) begin
                            r_hi <= r_hi_next;
                            r_lo <= r_lo_next;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs. The read port never bypasses a completing op; the stall
    // unit keeps mfhi/mflo out of E while busy.
    // ------------------------------------------------------------------
    logic [31:0] w_mdu_out;

    always_comb begin
        w_mdu_out = 32'd0;
        case (mdu.mdu_op)
            c_OP_MFHI: w_mdu_out = r_hi;
            c_OP_MFLO: w_mdu_out = r_lo;
            default:   w_mdu_out = 32'd0;
        endcase
    end

    assign mdu.busy    = r_busy;
    assign mdu.hi      = r_hi;
    assign mdu.lo      = r_lo;
    assign mdu.mdu_out = w_mdu_out;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mult_div_unit
//  Description : Directed self-checking bench for mult_div_unit. Expected
//                values are hand-computed constants.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_div_unit;

    localparam logic [3:0] c_NONE  = 4'd0;
    localparam logic [3:0] c_MULT  = 4'd1;
    localparam logic [3:0] c_MULTU = 4'd2;
    localparam logic [3:0] c_DIV   = 4'd3;
    localparam logic [3:0] c_DIVU  = 4'd4;
    localparam logic [3:0] c_MTHI  = 4'd5;
    localparam logic [3:0] c_MTLO  = 4'd6;
    localparam logic [3:0] c_MFHI  = 4'd7;
    localparam logic [3:0] c_MFLO  = 4'd8;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    mult_div_unit_if mdu_bus ();

    mult_div_unit #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .mdu   (mdu_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mdu_bus.start   = 1'b0;
        mdu_bus.mdu_op  = c_NONE;
        mdu_bus.rs_data = 32'd0;
        mdu_bus.rt_data = 32'd0;
    endtask

    // Issue a one-cycle start and count busy cycles (bounded).
    task automatic run_op(input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, output int cycles);
        mdu_bus.start   = 1'b1;
        mdu_bus.mdu_op  = op;
        mdu_bus.rs_data = a;
        mdu_bus.rt_data = b;
        tick();
        idle_inputs();
        cycles = 0;
        while (mdu_bus.busy === 1'b1 && cycles < 100) begin
            cycles++;
            tick();
        end
    endtask

    task automatic write_reg(input logic [3:0] op, input logic [31:0] val);
        mdu_bus.mdu_op  = op;
        mdu_bus.rs_data = val;
        tick();
        idle_inputs();
    endtask

    task automatic read_port(input logic [3:0] op, output logic [31:0] val);
        mdu_bus.mdu_op = op;
        #1;
        val = mdu_bus.mdu_out;
        mdu_bus.mdu_op = c_NONE;
    endtask

    initial begin
        int          cyc;
        logic [31:0] rd;

        n_checks = 0;
        n_fail   = 0;
        idle_inputs();

        // Reset
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check("reset_busy", {31'd0, mdu_bus.busy}, 32'd0);
        check("reset_hi", mdu_bus.hi, 32'd0);
        check("reset_lo", mdu_bus.lo, 32'd0);
        check("reset_out_none", mdu_bus.mdu_out, 32'd0);

        // MULT -2 * 3
        run_op(c_MULT, 32'hFFFF_FFFE, 32'd3, cyc);
        check("mult_cycles", 32'(cyc), 32'd5);
        check("mult_hi", mdu_bus.hi, 32'hFFFF_FFFF);
        check("mult_lo", mdu_bus.lo, 32'hFFFF_FFFA);
        read_port(c_MFLO, rd);
        check("mflo", rd, 32'hFFFF_FFFA);
        read_port(c_MFHI, rd);
        check("mfhi", rd, 32'hFFFF_FFFF);

        // MULTU max * max
        run_op(c_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc);
        check("multu_cycles", 32'(cyc), 32'd5);
        check("multu_hi", mdu_bus.hi, 32'hFFFF_FFFE);
        check("multu_lo", mdu_bus.lo, 32'h0000_0001);

        // DIV -7 / 2
        run_op(c_DIV, 32'hFFFF_FFF9, 32'd2, cyc);
        check("div_cycles", 32'(cyc), 32'd10);
        check("div_lo", mdu_bus.lo, 32'hFFFF_FFFD);
        check("div_hi", mdu_bus.hi, 32'hFFFF_FFFF);

        // DIV 7 / -2
        run_op(c_DIV, 32'd7, 32'hFFFF_FFFE, cyc);
        check("div_neg_divisor_lo", mdu_bus.lo, 32'hFFFF_FFFD);
        check("div_neg_divisor_hi", mdu_bus.hi, 32'd1);

        // DIVU 100 / 7
        run_op(c_DIVU, 32'd100, 32'd7, cyc);
        check("divu_cycles", 32'(cyc), 32'd10);
        check("divu_lo", mdu_bus.lo, 32'd14);
        check("divu_hi", mdu_bus.hi, 32'd2);

        // DIV overflow
        run_op(c_DIV, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
        check("div_ovf_lo", mdu_bus.lo, 32'h8000_0000);
        check("div_ovf_hi", mdu_bus.hi, 32'd0);

        // MTHI/MTLO then divide by zero
        write_reg(c_MTHI, 32'h0000_1234);
        write_reg(c_MTLO, 32'h0000_5678);
        check("mthi", mdu_bus.hi, 32'h0000_1234);
        check("mtlo", mdu_bus.lo, 32'h0000_5678);
        run_op(c_DIV, 32'd55, 32'd0, cyc);
        check("div0_cycles", 32'(cyc), 32'd10);
        check("div0_hi", mdu_bus.hi, 32'h0000_1234);
        check("div0_lo", mdu_bus.lo, 32'h0000_5678);
        run_op(c_DIVU, 32'd9, 32'd0, cyc);
        check("divu0_cycles", 32'(cyc), 32'd10);
        check("divu0_hi", mdu_bus.hi, 32'h0000_1234);

        // Reset during MULT 5x5 (asserted in the 3rd busy cycle)
        mdu_bus.start   = 1'b1;
        mdu_bus.mdu_op  = c_MULT;
        mdu_bus.rs_data = 32'd5;
        mdu_bus.rt_data = 32'd5;
        tick();
        idle_inputs();
        check("abort_busy_c1", {31'd0, mdu_bus.busy}, 32'd1);
        tick();
        check("abort_hi_stable", mdu_bus.hi, 32'h0000_1234);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_busy", {31'd0, mdu_bus.busy}, 32'd0);
        check("abort_hi", mdu_bus.hi, 32'd0);
        check("abort_lo", mdu_bus.lo, 32'd0);
        repeat (10) tick();
        check("abort_lo_late", mdu_bus.lo, 32'd0);
        check("abort_busy_late", {31'd0, mdu_bus.busy}, 32'd0);

        // Start + MTHI during busy are ignored
        mdu_bus.start   = 1'b1;
        mdu_bus.mdu_op  = c_MULT;
        mdu_bus.rs_data = 32'd6;
        mdu_bus.rt_data = 32'd7;
        tick();
        idle_inputs();
        cyc = 0;
        while (mdu_bus.busy === 1'b1 && cyc < 100) begin
            cyc++;
            idle_inputs();
            if (cyc == 1) begin
                mdu_bus.start   = 1'b1;
                mdu_bus.mdu_op  = c_DIV;
                mdu_bus.rs_data = 32'd100;
                mdu_bus.rt_data = 32'd3;
            end else if (cyc == 2) begin
                mdu_bus.mdu_op  = c_MTHI;
                mdu_bus.rs_data = 32'h0000_AAAA;
            end
            tick();
        end
        idle_inputs();
        check("ignore_cycles", 32'(cyc), 32'd5);
        check("ignore_hi", mdu_bus.hi, 32'd0);
        check("ignore_lo", mdu_bus.lo, 32'd42);
        repeat (3) tick();
        check("ignore_busy_after", {31'd0, mdu_bus.busy}, 32'd0);
        check("ignore_lo_after", mdu_bus.lo, 32'd42);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
